ud_mod_counter: RTL and testbench
=================================

UD_MOD_COUNTER -- requirements
Module: ud_mod_counter

Interface
REQ-001 Parameter WIDTH, default 3, SHALL set the count width in bits; legal range 1..16.
REQ-002 Parameter MODULUS, default 8, SHALL set the count range 0..MODULUS-1; legal range 2..2^WIDTH.
REQ-003 Parameter SATURATE, default 0, SHALL select the boundary mode: 0 wraps, 1 holds at the limit.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1 bit, SHALL be the clock; every state change occurs on its rising edge.
REQ-006 Port a_rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-007 Port clr, input, 1 bit, SHALL be a synchronous clear that forces the count to 0.
REQ-008 Port ld, input, 1 bit, SHALL be the parallel-load strobe.
REQ-009 Port Load, input, WIDTH bits, SHALL be the parallel-load value.
REQ-010 Port en, input, 1 bit, SHALL be the count enable.
REQ-011 Port up_down, input, 1 bit, SHALL select direction: 1 counts up, 0 counts down.
REQ-012 Port out, output, WIDTH bits, SHALL be the registered count.
REQ-013 Port cout, output, 1 bit, SHALL be the registered up-overflow pulse.
REQ-014 Port bout, output, 1 bit, SHALL be the registered down-underflow pulse.
REQ-015 Port tc_hi, output, 1 bit, SHALL be combinational and equal (out == MODULUS-1).
REQ-016 Port tc_lo, output, 1 bit, SHALL be combinational and equal (out == 0).
REQ-017 Port ld_err, output, 1 bit, SHALL be a sticky flag recording an out-of-range load.

Function
REQ-018 Priority per edge SHALL be a_rst > clr > ld > en; an idle cycle (no strobe and en=0) holds out.
REQ-019 For clr=1, the block SHALL set out=0 and cout=bout=0, and SHALL clear ld_err.
REQ-020 For ld=1 with Load<MODULUS, the block SHALL set out=Load; ld_err is unchanged.
REQ-021 For ld=1 with Load>=MODULUS, the block SHALL set out=MODULUS-1 and ld_err=1.
REQ-022 For a load cycle, the block SHALL drive cout=bout=0 regardless of en and up_down.
REQ-023 For en=1, up_down=1 and out<MODULUS-1, the block SHALL set out=out+1.
REQ-024 For en=1, up_down=0 and out>0, the block SHALL set out=out-1.
REQ-025 For SATURATE=0, en=1, up_down=1 and out=MODULUS-1, the block SHALL set out=0 and cout=1.
REQ-026 For SATURATE=0, en=1, up_down=0 and out=0, the block SHALL set out=MODULUS-1 and bout=1.
REQ-027 For SATURATE=1 at either limit, the block SHALL hold out and pulse cout (up) or bout (down) to flag the blocked step.
REQ-028 cout and bout SHALL each be high for exactly the one cycle after the causing edge, and SHALL be 0 in every other cycle.
REQ-029 cout and bout SHALL never be high in the same cycle.
REQ-030 Arithmetic SHALL be computed WIDTH+1 bits wide; for MODULUS=2^WIDTH, wrap SHALL equal natural binary overflow.
REQ-031 Latency SHALL be one clock from an input edge to out, cout and bout; tc_hi and tc_lo follow out with zero latency.
REQ-032 A change of up_down between enabled cycles SHALL take effect on the next edge, with no dead cycle.

Reset
REQ-033 For a_rst=1 at a rising edge, the block SHALL set out=0, cout=0, bout=0 and ld_err=0, overriding clr, ld and en.
REQ-034 After a_rst deasserts, the first edge SHALL act on clr, ld or en normally, with no extra delay.
REQ-035 Before the first rising edge with a_rst=1, output values SHALL be don't-care; the bench SHALL check only after reset.
REQ-036 A reset asserted mid-count SHALL discard any pending cout or bout pulse.

Verification (WIDTH=3, MODULUS=6 unless noted)
REQ-037 Scenario: reset, then en=1 and up_down=1 for 7 edges -> out sequence 1,2,3,4,5,0,1; cout high only in the cycle out=0; tc_hi high only when out=5.
REQ-038 Scenario: out=0, then en=1 and up_down=0 for 2 edges -> out 5 then 4; bout high only in the cycle out=5.
REQ-039 Scenario: ld=1 with Load=7 -> out=5 and ld_err=1; then clr=1 -> out=0 and ld_err=0.
REQ-040 Scenario: SATURATE=1, out=5, en=1, up_down=1 for 2 edges -> out stays 5 and cout pulses each cycle; same check at out=0 counting down with bout.
REQ-041 Scenario: ld=1, en=1 and clr=1 together -> out=0; then a_rst=1 with ld=1 -> out=0 and no pulses.
REQ-042 Scenario: WIDTH=3, MODULUS=8, count up from 7 -> out=0 and cout=1; a_rst asserted during that pulse cycle -> cout=0 on the next edge.

Source files
------------

// File: rtl/ud_mod_counter.sv
// ud_mod_counter: loadable up/down modulo-MODULUS counter.
// Boundary steps either wrap (SATURATE=0) or hold (SATURATE=1). In both
// modes they raise a one-cycle cout/bout pulse. Out-of-range loads clamp
// to MODULUS-1 and set a sticky ld_err flag, which only reset or clr clears.
module ud_mod_counter #(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             a_rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] Load,
    input  logic             en,
    input  logic             up_down,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             bout,
    output logic             tc_hi,
    output logic             tc_lo,
    output logic             ld_err
);

    // All boundary arithmetic is one bit wider than the count. This lets
    // MODULUS == 2**WIDTH be represented and compared without truncation.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_CLR,
        OP_LOAD,
        OP_UP,
        OP_DOWN
    } op_e;

    op_e              op;
    logic [WIDTH-1:0] cnt_q,    cnt_d;
    logic             cout_q,   cout_d;
    logic             bout_q,   bout_d;
    logic             ld_err_q, ld_err_d;

    logic [WIDTH:0]   cnt_inc;
    logic [WIDTH:0]   cnt_dec;
    logic             at_max;
    logic             at_zero;
    logic             load_oor;

    // Widened step values and boundary detection.
    // at_max: the incremented value reaches MODULUS. For a full binary
    // range, this is exactly the natural carry out of the counter.
    // at_zero: the decrement borrows out of the counter width.
    assign cnt_inc  = {1'b0, cnt_q} + ONE_EXT;
    assign cnt_dec  = {1'b0, cnt_q} - ONE_EXT;
    assign at_max   = (cnt_inc == MOD_EXT);
    assign at_zero  = cnt_dec[WIDTH];
    assign load_oor = ({1'b0, Load} >= MOD_EXT);

    // Per-edge operation select. Priority is clr > ld > en. Reset is
    // applied separately, in the register process.
    always_comb begin
        op = OP_IDLE;
        if (clr) begin
            op = OP_CLR;
        end else if (ld) begin
            op = OP_LOAD;
        end else if (en) begin
            op = up_down ? OP_UP : OP_DOWN;
        end
    end

    // Next-state count, boundary pulses and sticky load error.
    always_comb begin
        cnt_d    = cnt_q;
        cout_d   = 1'b0;
        bout_d   = 1'b0;
        ld_err_d = ld_err_q;
        unique case (op)
            OP_CLR: begin
                cnt_d    = '0;
                ld_err_d = 1'b0;
            end
            OP_LOAD: begin
                if (load_oor) begin
                    cnt_d    = MAX_VAL;
                    ld_err_d = 1'b1;
                end else begin
                    cnt_d = Load;
                end
            end
            OP_UP: begin
                if (at_max) begin
                    cout_d = 1'b1;
                    if (!SATURATE) begin
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_inc[WIDTH-1:0];
                end
            end
            OP_DOWN: begin
                if (at_zero) begin
                    bout_d = 1'b1;
                    if (!SATURATE) begin
                        cnt_d = MAX_VAL;
                    end
                end else begin
                    cnt_d = cnt_dec[WIDTH-1:0];
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // State register with synchronous active-high reset.
    // Reset drops any pulse that would otherwise be raised on this edge.
    always_ff @(posedge clk) begin
        if (a_rst) begin
            cnt_q    <= '0;
            cout_q   <= 1'b0;
            bout_q   <= 1'b0;
            ld_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            cout_q   <= cout_d;
            bout_q   <= bout_d;
            ld_err_q <= ld_err_d;
        end
    end

    assign out    = cnt_q;
    assign cout   = cout_q;
    assign bout   = bout_q;
    assign ld_err = ld_err_q;
    assign tc_hi  = (cnt_q == MAX_VAL);
    assign tc_lo  = (cnt_q == '0);

endmodule

// File: tb/tb_ud_mod_counter.sv
// Directed bench for ud_mod_counter. It drives three instances from shared
// inputs:
//   A = W3/M6 wrap, B = W3/M6 saturate, C = W3/M8 wrap.
module tb_ud_mod_counter;

    logic       clk = 1'b0;
    logic       a_rst, clr, ld, en, up_down;
    logic [2:0] Load;

    logic [2:0] out_a, out_b, out_c;
    logic       cout_a, bout_a, tchi_a, tclo_a, err_a;
    logic       cout_b, bout_b, tchi_b, tclo_b, err_b;
    logic       cout_c, bout_c, tchi_c, tclo_c, err_c;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    int unsigned exp_a[7] = '{1, 2, 3, 4, 5, 0, 1};
    int unsigned exp_b[7] = '{1, 2, 3, 4, 5, 5, 5};

    always #5 clk = ~clk;

    ud_mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(1'b0)) u_a (
        .clk(clk), .a_rst(a_rst), .clr(clr), .ld(ld), .Load(Load), .en(en),
        .up_down(up_down), .out(out_a), .cout(cout_a), .bout(bout_a),
        .tc_hi(tchi_a), .tc_lo(tclo_a), .ld_err(err_a)
    );

    ud_mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(1'b1)) u_b (
        .clk(clk), .a_rst(a_rst), .clr(clr), .ld(ld), .Load(Load), .en(en),
        .up_down(up_down), .out(out_b), .cout(cout_b), .bout(bout_b),
        .tc_hi(tchi_b), .tc_lo(tclo_b), .ld_err(err_b)
    );

    ud_mod_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) u_c (
        .clk(clk), .a_rst(a_rst), .clr(clr), .ld(ld), .Load(Load), .en(en),
        .up_down(up_down), .out(out_c), .cout(cout_c), .bout(bout_c),
        .tc_hi(tchi_c), .tc_lo(tclo_c), .ld_err(err_c)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_total++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic c, input logic l,
                         input logic [2:0] lv, input logic e, input logic u);
        a_rst   = r;
        clr     = c;
        ld      = l;
        Load    = lv;
        en      = e;
        up_down = u;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        check("rst out_a", out_a, 0);
        check("rst cout_a", cout_a, 0);
        check("rst bout_a", bout_a, 0);
        check("rst err_a", err_a, 0);
        check("rst tclo_a", tclo_a, 1);
        check("rst tchi_a", tchi_a, 0);
        check("rst out_c", out_c, 0);

        // Count up 7 edges: A wraps at 5, B holds at 5, C climbs to 7.
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("up%0d out_a", i), out_a, exp_a[i]);
            check($sformatf("up%0d cout_a", i), cout_a, (i == 5) ? 1 : 0);
            check($sformatf("up%0d tchi_a", i), tchi_a, (i == 4) ? 1 : 0);
            check($sformatf("up%0d out_b", i), out_b, exp_b[i]);
            check($sformatf("up%0d cout_b", i), cout_b, (i >= 5) ? 1 : 0);
            check($sformatf("up%0d out_c", i), out_c, i + 1);
        end

        // Full binary range: 7 -> 0 is a natural overflow.
        tick();
        check("wrap8 out_c", out_c, 0);
        check("wrap8 cout_c", cout_c, 1);
        check("wrap8 bout_c", bout_c, 0);
        check("wrap8 out_a", out_a, 2);
        repeat (7) tick();
        check("climb out_c", out_c, 7);
        check("climb out_a", out_a, 3);

        // Reset on an edge that would have overflowed C and B.
        drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
        tick();
        check("rstpend out_c", out_c, 0);
        check("rstpend cout_c", cout_c, 0);
        check("rstpend cout_b", cout_b, 0);
        check("rstpend out_b", out_b, 0);
        check("rstpend out_a", out_a, 0);

        // Count down from 0, starting on the first edge after reset.
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        tick();
        check("dn0 out_a", out_a, 5);
        check("dn0 bout_a", bout_a, 1);
        check("dn0 tchi_a", tchi_a, 1);
        check("dn0 out_b", out_b, 0);
        check("dn0 bout_b", bout_b, 1);
        check("dn0 out_c", out_c, 7);
        check("dn0 bout_c", bout_c, 1);
        tick();
        check("dn1 out_a", out_a, 4);
        check("dn1 bout_a", bout_a, 0);
        check("dn1 out_b", out_b, 0);
        check("dn1 bout_b", bout_b, 1);
        check("dn1 tclo_b", tclo_b, 1);
        check("dn1 out_c", out_c, 6);

        // Loads: an out-of-range load clamps; a load beats en and suppresses pulses.
        drive(1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0);
        tick();
        check("ld7 out_a", out_a, 5);
        check("ld7 err_a", err_a, 1);
        check("ld7 out_c", out_c, 7);
        check("ld7 err_c", err_c, 0);
        drive(1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 1'b1);
        tick();
        check("ld5en out_a", out_a, 5);
        check("ld5en cout_a", cout_a, 0);
        check("ld5en err_a", err_a, 1);
        check("ld5en cout_c", cout_c, 0);
        drive(1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
        tick();
        check("ld3dn out_a", out_a, 3);
        check("ld3dn bout_a", bout_a, 0);
        check("ld3dn err_a", err_a, 1);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        check("clr out_a", out_a, 0);
        check("clr err_a", err_a, 0);

        // clr beats ld and en; reset beats all of them.
        drive(1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0);
        tick();
        check("reld7 err_a", err_a, 1);
        drive(1'b0, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1);
        tick();
        check("clrld out_a", out_a, 0);
        check("clrld err_a", err_a, 0);
        check("clrld cout_a", cout_a, 0);
        drive(1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
        tick();
        check("rstld out_a", out_a, 0);
        check("rstld bout_a", bout_a, 0);
        check("rstld cout_a", cout_a, 0);

        // A direction change takes effect on the very next edge.
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
        tick();
        check("dir0 out_a", out_a, 1);
        up_down = 1'b0;
        tick();
        check("dir1 out_a", out_a, 0);
        check("dir1 tclo_a", tclo_a, 1);
        tick();
        check("dir2 out_a", out_a, 5);
        check("dir2 bout_a", bout_a, 1);
        up_down = 1'b1;
        tick();
        check("dir3 out_a", out_a, 0);
        check("dir3 cout_a", cout_a, 1);
        check("dir3 bout_a", bout_a, 0);
        en = 1'b0;
        tick();
        check("idle out_a", out_a, 0);
        check("idle cout_a", cout_a, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
